// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and defaults for the UART transmit/receive blocks.
//             Holds the transmitter state encoding and default frame sizing.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } tx_state_t;

   localparam int DATA_WIDTH_DEF   = 8;
   localparam int CLKS_PER_BIT_DEF = 16;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_gen
//  Purpose  : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; bit_done
//             pulses on the last cycle of every bit period.
//  Ports    : r_clk    - clock (rising edge)
//             r_rst    - synchronous active-high reset
//             clr      - holds the counter at zero (aligns the next period)
//             bit_done - one-cycle pulse on the final cycle of a bit
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic r_clk,
   input  logic r_rst,
   input  logic clr,
   output logic bit_done
);

   // At least one bit so CLKS_PER_BIT=1 still has a legal counter; it then
   // sits at zero and bit_done is permanently high.
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign bit_done = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr || bit_done) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_drain
//  Purpose  : Read-side consumer of the async FIFO. Pops a word whenever the
//             FIFO is not empty and the transmitter is idle, then sends it as
//             a UART frame: start bit, LSB-first data, optional parity, stop.
//  Ports    : r_clk  - read-domain clock (rising edge)
//             r_rst  - synchronous active-high reset
//             empty  - FIFO empty flag (r_clk domain)
//             rdata  - FIFO read data, valid the cycle after r_en
//             r_en   - FIFO pop strobe, one cycle per word
//             tx     - registered serial line, idles high
//             busy   - high whenever a word is being fetched or sent
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_drain
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  r_clk,
   input  logic                  r_rst,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  r_en,
   output logic                  tx,
   output logic                  busy
);

   localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_STOP_BIT = BIT_CNT_W'(STOP_BITS - 1);
   localparam logic PARITY_INV = 1'(PARITY_ODD);

   tx_state_t             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  parity_q, parity_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic                  tx_q, tx_d;
   logic                  baud_clr;
   logic                  bit_done;

   // Reset gates the pop so no word is consumed while reset is held.
   assign r_en = (state_q == IDLE) && !empty && !r_rst;
   assign busy = (state_q != IDLE);
   assign tx   = tx_q;

   // Holding the timer clear through IDLE/FETCH makes the start bit begin a
   // fresh bit period.
   assign baud_clr = (state_q == IDLE) || (state_q == FETCH);

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_gen (
      .r_clk    (r_clk),
      .r_rst    (r_rst),
      .clr      (baud_clr),
      .bit_done (bit_done)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      bit_cnt_d = bit_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (r_en) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            shift_d   = rdata;
            parity_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = START;
         end
         START: begin
            if (bit_done) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_d  = shift_q >> 1;
               parity_d = parity_q ^ shift_q[0];
               if (bit_cnt_q == LAST_DATA_BIT) begin
                  // Counter is reused to count stop bits.
                  bit_cnt_d = '0;
                  state_d   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (bit_cnt_q == LAST_STOP_BIT) begin
                  state_d = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Line level is derived from the next state so the registered tx lines
      // up cycle-for-cycle with the state register.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = parity_d ^ PARITY_INV;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
      end
   end

endmodule : uart_tx_drain
`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_tx_drain
//  Purpose  : Self-checking bench. Five differently configured transmitters
//             share one clock, reset and word stream; each has its own FIFO
//             stand-in and a frame-level expectation queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_drain;

   localparam int NI = 5;
   localparam int P_DW  [NI] = '{8, 8, 8, 8, 5};
   localparam int P_CPB [NI] = '{4, 4, 4, 3, 1};
   localparam int P_PE  [NI] = '{0, 1, 1, 0, 1};
   localparam int P_PO  [NI] = '{0, 0, 1, 0, 0};
   localparam int P_SB  [NI] = '{1, 1, 1, 2, 2};

   logic          clk        = 1'b0;
   logic          rst        = 1'b1;
   logic          push_v     = 1'b0;
   logic [8:0]    push_w     = '0;
   logic          hold_empty = 1'b1;
   logic [NI-1:0] ren_v;
   logic [NI-1:0] tx_v;
   logic [NI-1:0] busy_v;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int DW  = P_DW[gi];
      localparam int CPB = P_CPB[gi];
      localparam int PE  = P_PE[gi];
      localparam int PO  = P_PO[gi];
      localparam int SB  = P_SB[gi];

      logic [DW-1:0] rdata   = '0;
      logic          empty_i = 1'b1;
      int unsigned   fifo[$];
      int unsigned   mq[$];
      logic [1:0]    expq[$];   // per-cycle {tx, busy} of the frame in flight
      logic [2:0]    exp_o;
      logic [2:0]    got_o;
      int unsigned   w;
      logic          pbit;

      uart_tx_drain #(
         .DATA_WIDTH   (DW),
         .CLKS_PER_BIT (CPB),
         .PARITY_EN    (PE),
         .PARITY_ODD   (PO),
         .STOP_BITS    (SB)
      ) u_dut (
         .r_clk (clk),
         .r_rst (rst),
         .empty (empty_i),
         .rdata (rdata),
         .r_en  (ren_v[gi]),
         .tx    (tx_v[gi]),
         .busy  (busy_v[gi])
      );

      // FIFO stand-in with a registered read port.
      always @(posedge clk) begin
         if (ren_v[gi] && fifo.size() != 0) begin
            rdata <= DW'(fifo.pop_front());
         end
         if (push_v) begin
            fifo.push_back(32'(push_w));
            mq.push_back(32'(push_w));
         end
         empty_i <= (fifo.size() == 0) || hold_empty;
      end

      // Frame-level model: when idle it pops on !empty; a pop expands into
      // one fetch cycle followed by the full bit sequence of the frame.
      always @(negedge clk) begin
         if (expq.size() != 0) begin
            exp_o = {1'b0, expq[0]};
         end else begin
            exp_o = {(!rst && !empty_i), 1'b1, 1'b0};
         end
         got_o = {ren_v[gi], tx_v[gi], busy_v[gi]};
         checks++;
         if (got_o !== exp_o) begin
            errors++;
            $display("FAIL model inst%0d t=%0t r_en/tx/busy got %b expected %b",
                     gi, $time, got_o, exp_o);
         end
         if (rst) begin
            expq.delete();
         end else if (expq.size() != 0) begin
            void'(expq.pop_front());
         end else if (exp_o[2]) begin
            if (mq.size() == 0) begin
               errors++;
               $display("FAIL model inst%0d pop with no word queued", gi);
            end else begin
               w = mq.pop_front();
               pbit = 1'(PO);
               expq.push_back(2'b11);
               for (int c = 0; c < CPB; c++) expq.push_back(2'b01);
               for (int b = 0; b < DW; b++) begin
                  pbit = pbit ^ w[b];
                  for (int c = 0; c < CPB; c++) expq.push_back({w[b], 1'b1});
               end
               if (PE != 0) begin
                  for (int c = 0; c < CPB; c++) expq.push_back({pbit, 1'b1});
               end
               for (int c = 0; c < SB * CPB; c++) expq.push_back(2'b11);
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic push(input int wd);
      @(posedge clk);
      #1 push_v = 1'b1;
      push_w = 9'(wd);
      @(posedge clk);
      #1 push_v = 1'b0;
   endtask

   task automatic wait_ren(input int idx);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ren_v[idx]) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL wait_ren inst%0d timeout got 0 expected 1", idx);
      end
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (busy_v == '0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL wait_idle timeout busy got %b expected 0", busy_v);
      end
   endtask

   // Observes instance 0 from the cycle after its pop: slot-centre tx
   // samples, cycles from pop to busy falling, and further pops.
   task automatic frame0(output logic [9:0] pat, output int span, output int pops);
      pat  = '0;
      span = 1;
      pops = 0;
      for (int c = 1; c <= 44; c++) begin
         @(negedge clk);
         if (c >= 4 && c <= 40 && (c % 4) == 0) pat = {pat[8:0], tx_v[0]};
         if (busy_v[0]) span++;
         if (ren_v[0]) pops++;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] pat;
      int         span, pops, f1, f2, n3;
      logic       prev, b35, t8, t40a, t40b;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", int'({ren_v[0], tx_v[0], busy_v[0]}), 2);

      // Empty held: nothing may move.
      n3 = 0;
      repeat (100) begin
         @(negedge clk);
         if (ren_v != '0 || busy_v != '0 || tx_v != '1) n3++;
      end
      chk("idle_quiet", n3, 0);

      // Single word 0xA5.
      push(8'hA5);
      hold_empty = 1'b0;
      wait_ren(0);
      frame0(pat, span, pops);
      chk("a5_slots", int'(pat), int'(10'b0101001011));
      chk("a5_pop_to_idle", span, 42);
      chk("a5_single_pop", pops, 0);
      wait_idle();

      // Two words back to back: 0x00 then 0xFF.
      hold_empty = 1'b1;
      push(8'h00);
      push(8'hFF);
      hold_empty = 1'b0;
      wait_ren(0);
      pops = 1; f1 = -1; f2 = -1; prev = tx_v[0];
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (ren_v[0]) pops++;
         if (prev && !tx_v[0]) begin
            if (f1 < 0) f1 = c;
            else if (f2 < 0) f2 = c;
         end
         prev = tx_v[0];
      end
      chk("b2b_pops", pops, 2);
      chk("b2b_first_start", f1, 2);
      chk("b2b_start_to_start", f2 - f1, 42);
      wait_idle();

      // 0x07: parity slots, CPB=1 instance, two stop bits.
      hold_empty = 1'b1;
      push(8'h07);
      hold_empty = 1'b0;
      wait_ren(1);
      n3 = 0; b35 = 1'b1; t8 = 1'b0; t40a = 1'b0; t40b = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 8) t8 = tx_v[4];
         if (c >= 29 && c <= 34 && tx_v[3] && busy_v[3]) n3++;
         if (c == 35) b35 = busy_v[3];
         if (c == 40) begin
            t40a = tx_v[1];
            t40b = tx_v[2];
         end
      end
      chk("parity_even", int'(t40a), 1);
      chk("parity_odd", int'(t40b), 0);
      chk("parity_cpb1", int'(t8), 1);
      chk("stop2_high_cycles", n3, 6);
      chk("stop2_busy_after", int'(b35), 0);
      wait_idle();

      // Reset during the data bits of 0x3C.
      hold_empty = 1'b1;
      push(8'h3C);
      hold_empty = 1'b0;
      wait_ren(0);
      repeat (14) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      hold_empty = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_frame", int'({ren_v[0], tx_v[0], busy_v[0]}), 2);
      push(8'h3C);
      hold_empty = 1'b0;
      wait_ren(0);
      frame0(pat, span, pops);
      chk("post_rst_slots", int'(pat), int'(10'b0001111001));
      chk("post_rst_pop_to_idle", span, 42);
      chk("post_rst_single_pop", pops, 0);
      wait_idle();

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_uart_tx_drain
`default_nettype wire
